// File: rtl/cpu7_ifu_pkg.sv
// ---------------------------------------------------------------------------
// cpu7_ifu_pkg
// Shared definitions for the cpu7 IFU decode-stage controller and its queue.
//   DEPTH        : decode queue depth (fixed at 2)
//   PC_W         : PC width held in each queue entry (matches the GRLEN default)
//   dctl_state_t : controller state (RUN, REDIR)
//   dq_entry_t   : one queued fetch record (instruction word + PC)
// ---------------------------------------------------------------------------
package cpu7_ifu_pkg;

    localparam logic [1:0] DEPTH = 2'd2;
    localparam int         PC_W  = 32;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } dctl_state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } dq_entry_t;

endpackage

// File: rtl/cpu7_ifu_dq.sv
// ---------------------------------------------------------------------------
// cpu7_ifu_dq
// Two-entry in-order instruction queue with 1-bit head/tail pointers.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clear                 : drop all entries (wins over push/pop)
//   push, wr_inst, wr_pc  : enqueue one entry at the tail
//   pop                   : dequeue the head entry
//   head_inst, head_pc    : head entry contents (raw storage, not gated)
//   count                 : number of valid entries, 0..2
// ---------------------------------------------------------------------------
module cpu7_ifu_dq
    import cpu7_ifu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic [31:0]     wr_inst,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            pop,
    output logic [31:0]     head_inst,
    output logic [PC_W-1:0] head_pc,
    output logic [1:0]      count
);

    dq_entry_t  entries_q [2];
    dq_entry_t  entries_d [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (clear) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                entries_d[tail_q] = '{inst: wr_inst, pc: wr_pc};
                tail_d            = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointers and count are control; entry payload needs no reset because it
    // is only observed through count.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign head_inst = entries_q[head_q].inst;
    assign head_pc   = entries_q[head_q].pc;
    assign count     = count_q;

endmodule

// File: rtl/cpu7_ifu_dctl.sv
// ---------------------------------------------------------------------------
// cpu7_ifu_dctl
// Decode-stage controller: buffers fetched instructions in a 2-entry queue,
// presents the head to the decoder/EXU with valid/ready, handles EXU flush and
// (optionally) early fetch redirect for unconditional direct branches.
// Build option: define CPU7_IFU_DCTL_EARLY_BR_EN to build the early-redirect
// path and REDIR state; otherwise redirect outputs are tied to 0.
// Ports:
//   clk, reset                            : clock, sync active-high reset
//   fdp_dec_valid/inst/pc, dec_fdp_ready  : fetch -> queue handshake
//   dec_inst_d, dec_br_offs, dec_is_dbr   : head to decoder, decoder results
//   dec_exu_valid/pc, exu_dec_ready       : head -> EXU handshake
//   exu_ifu_flush                         : kill queued entries and redirect
//   dec_fdp_redirect/target, fdp_dec_redirect_ack : early redirect to fetch
// GRLEN must equal cpu7_ifu_pkg::PC_W.
// ---------------------------------------------------------------------------
module cpu7_ifu_dctl
    import cpu7_ifu_pkg::*;
#(
    parameter int GRLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fdp_dec_valid,
    input  logic [31:0]      fdp_dec_inst,
    input  logic [GRLEN-1:0] fdp_dec_pc,
    output logic             dec_fdp_ready,
    output logic [31:0]      dec_inst_d,
    input  logic [GRLEN-1:0] dec_br_offs,
    input  logic             dec_is_dbr,
    output logic             dec_exu_valid,
    output logic [GRLEN-1:0] dec_exu_pc,
    input  logic             exu_dec_ready,
    input  logic             exu_ifu_flush,
    output logic             dec_fdp_redirect,
    output logic [GRLEN-1:0] dec_fdp_target,
    input  logic             fdp_dec_redirect_ack
);

    logic [1:0]       q_count;
    logic [31:0]      q_head_inst;
    logic [GRLEN-1:0] q_head_pc;
    logic             q_clear;
    logic             run;
    logic             head_vld;
    logic             push;
    logic             pop;

    // Outputs are forced idle while reset is held, including ready.
    assign head_vld      = ~reset & (q_count != 2'd0);
    assign dec_exu_valid = head_vld & run;
    assign dec_fdp_ready = ~reset & run & (q_count != DEPTH);
    assign dec_inst_d    = head_vld ? q_head_inst : 32'd0;
    assign dec_exu_pc    = head_vld ? q_head_pc : '0;

    assign push = fdp_dec_valid & dec_fdp_ready;
    assign pop  = dec_exu_valid & exu_dec_ready;

`ifdef CPU7_IFU_DCTL_EARLY_BR_EN
    dctl_state_t      state_q, state_d;
    logic [GRLEN-1:0] target_q, target_d;
    logic             br_take;

    assign br_take = pop & dec_is_dbr;
    assign run     = (state_q == RUN);
    // A taken direct branch discards the younger entry and any same-cycle push.
    assign q_clear = exu_ifu_flush | br_take;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            RUN: begin
                if (br_take) begin
                    state_d  = REDIR;
                    target_d = dec_exu_pc + dec_br_offs;
                end
            end
            REDIR: begin
                if (fdp_dec_redirect_ack) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (exu_ifu_flush) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign dec_fdp_redirect = ~reset & (state_q == REDIR);
    assign dec_fdp_target   = reset ? '0 : target_q;
`else
    logic unused_br;

    assign unused_br        = ^{dec_is_dbr, dec_br_offs, fdp_dec_redirect_ack};
    assign run              = 1'b1;
    assign q_clear          = exu_ifu_flush;
    assign dec_fdp_redirect = 1'b0;
    assign dec_fdp_target   = '0;
`endif

    cpu7_ifu_dq u_dq (
        .clk       (clk),
        .reset     (reset),
        .clear     (q_clear),
        .push      (push),
        .wr_inst   (fdp_dec_inst),
        .wr_pc     (fdp_dec_pc),
        .pop       (pop),
        .head_inst (q_head_inst),
        .head_pc   (q_head_pc),
        .count     (q_count)
    );

endmodule
